// File: rtl/ram_responder.sv
// Dual-port word RAM for instruction fetch (port 1) and LDR/STR (port 2); optional RAM_WR_FWD_EN forwarding.
// Read data after READ_LAT cycles, both ports fully pipelined with no backpressure; err_addr is sticky.
module ram_responder #(
   parameter int ADDR_W   = 11,
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 2048,
   parameter int READ_LAT = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ram_req1,
   input  logic              ram_w_en1,
   input  logic [ADDR_W-1:0] ram_addr1,
   input  logic [DATA_W-1:0] ram_wdata1,
   output logic [DATA_W-1:0] ram_rdata1,
   output logic              ram_rvalid1,
   input  logic              ram_req2,
   input  logic              ram_w_en2,
   input  logic [ADDR_W-1:0] ram_addr2,
   input  logic [DATA_W-1:0] ram_wdata2,
   output logic [DATA_W-1:0] ram_rdata2,
   output logic              ram_rvalid2,
   output logic              err_addr
);

   localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];

   logic              oob1, oob2;
   logic              rd1, rd2, wr1, wr2;
   logic [IDX_W-1:0]  idx1, idx2;
   logic [DATA_W-1:0] rd_word1, rd_word2;

   logic [READ_LAT-1:0] v1, v2;
   logic [DATA_W-1:0]   d1 [READ_LAT];
   logic [DATA_W-1:0]   d2 [READ_LAT];

   assign oob1 = ({1'b0, ram_addr1} >= DEPTH_X);
   assign oob2 = ({1'b0, ram_addr2} >= DEPTH_X);
   assign idx1 = ram_addr1[IDX_W-1:0];
   assign idx2 = ram_addr2[IDX_W-1:0];

   assign rd1 = ram_req1 & ~ram_w_en1;
   assign rd2 = ram_req2 & ~ram_w_en2;
   // Out-of-range writes are dropped here, so the array never aliases them.
   assign wr1 = ram_req1 & ram_w_en1 & ~oob1;
   assign wr2 = ram_req2 & ram_w_en2 & ~oob2;

   // Port 2 is written last so it wins a same-address double write.
   always_ff @(posedge clk) begin
      if (wr1) mem[idx1] <= ram_wdata1;
      if (wr2) mem[idx2] <= ram_wdata2;
   end

   always_comb begin
      rd_word1 = oob1 ? '0 : mem[idx1];
      rd_word2 = oob2 ? '0 : mem[idx2];
`ifdef RAM_WR_FWD_EN
      if (wr2 && (ram_addr2 == ram_addr1)) rd_word1 = ram_wdata2;
      if (wr1 && (ram_addr1 == ram_addr2)) rd_word2 = ram_wdata1;
`endif
   end

   // Data stages only advance with a valid token, so the output holds the last read word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1 <= '0;
         v2 <= '0;
         for (int i = 0; i < READ_LAT; i++) begin
            d1[i] <= '0;
            d2[i] <= '0;
         end
      end else begin
         v1[0] <= rd1;
         v2[0] <= rd2;
         if (rd1) d1[0] <= rd_word1;
         if (rd2) d2[0] <= rd_word2;
         for (int i = 1; i < READ_LAT; i++) begin
            v1[i] <= v1[i-1];
            v2[i] <= v2[i-1];
            if (v1[i-1]) d1[i] <= d1[i-1];
            if (v2[i-1]) d2[i] <= d2[i-1];
         end
      end
   end

   assign ram_rvalid1 = v1[READ_LAT-1];
   assign ram_rdata1  = d1[READ_LAT-1];
   assign ram_rvalid2 = v2[READ_LAT-1];
   assign ram_rdata2  = d2[READ_LAT-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_addr <= 1'b0;
      else if ((ram_req1 && oob1) || (ram_req2 && oob2))
         err_addr <= 1'b1;
   end

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder (DEPTH=1024, READ_LAT=2); expectations depend on RAM_WR_FWD_EN.
module tb_ram_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ram_req1 = 1'b0, ram_w_en1 = 1'b0;
   logic [10:0] ram_addr1 = '0;
   logic [31:0] ram_wdata1 = '0;
   logic [31:0] ram_rdata1;
   logic        ram_rvalid1;
   logic        ram_req2 = 1'b0, ram_w_en2 = 1'b0;
   logic [10:0] ram_addr2 = '0;
   logic [31:0] ram_wdata2 = '0;
   logic [31:0] ram_rdata2;
   logic        ram_rvalid2;
   logic        err_addr;

   int checks = 0;
   int failures = 0;

   ram_responder #(.ADDR_W(11), .DATA_W(32), .DEPTH(1024), .READ_LAT(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .ram_req1(ram_req1), .ram_w_en1(ram_w_en1), .ram_addr1(ram_addr1),
      .ram_wdata1(ram_wdata1), .ram_rdata1(ram_rdata1), .ram_rvalid1(ram_rvalid1),
      .ram_req2(ram_req2), .ram_w_en2(ram_w_en2), .ram_addr2(ram_addr2),
      .ram_wdata2(ram_wdata2), .ram_rdata2(ram_rdata2), .ram_rvalid2(ram_rvalid2),
      .err_addr(err_addr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      ram_req1 = 1'b0; ram_w_en1 = 1'b0;
      ram_req2 = 1'b0; ram_w_en2 = 1'b0;
   endtask

   task automatic wr(input int port, input logic [10:0] addr, input logic [31:0] data);
      if (port == 1) begin
         ram_req1 = 1'b1; ram_w_en1 = 1'b1; ram_addr1 = addr; ram_wdata1 = data;
      end else begin
         ram_req2 = 1'b1; ram_w_en2 = 1'b1; ram_addr2 = addr; ram_wdata2 = data;
      end
      tick();
      idle();
   endtask

   task automatic do_read(input string tag, input int port, input logic [10:0] addr,
                          input logic [31:0] exp);
      if (port == 1) begin
         ram_req1 = 1'b1; ram_w_en1 = 1'b0; ram_addr1 = addr;
      end else begin
         ram_req2 = 1'b1; ram_w_en2 = 1'b0; ram_addr2 = addr;
      end
      tick();
      idle();
      check({tag, "_early"}, 32'((port == 1) ? ram_rvalid1 : ram_rvalid2), 32'd0);
      tick();
      check({tag, "_vld"}, 32'((port == 1) ? ram_rvalid1 : ram_rvalid2), 32'd1);
      check({tag, "_dat"}, (port == 1) ? ram_rdata1 : ram_rdata2, exp);
      tick();
      check({tag, "_pulse"}, 32'((port == 1) ? ram_rvalid1 : ram_rvalid2), 32'd0);
   endtask

   initial begin
      logic [31:0] exp_fwd;
`ifdef RAM_WR_FWD_EN
      exp_fwd = 32'h2;
`else
      exp_fwd = 32'h1;
`endif
      tick(); tick();
      check("rst_rvalid1", 32'(ram_rvalid1), 32'd0);
      check("rst_rvalid2", 32'(ram_rvalid2), 32'd0);
      check("rst_rdata1", ram_rdata1, 32'd0);
      check("rst_rdata2", ram_rdata2, 32'd0);
      check("rst_err", 32'(err_addr), 32'd0);
      rst_n = 1'b1;
      tick();

      // write then immediate read of the same word
      wr(2, 11'd5, 32'hDEADBEEF);
      do_read("rd5", 1, 11'd5, 32'hDEADBEEF);

      // back-to-back reads
      wr(1, 11'd0, 32'h10);
      wr(1, 11'd1, 32'h11);
      wr(2, 11'd2, 32'h12);
      ram_req1 = 1'b1; ram_addr1 = 11'd0;
      tick();
      ram_addr1 = 11'd1;
      check("b2b_v0", 32'(ram_rvalid1), 32'd0);
      tick();
      ram_addr1 = 11'd2;
      check("b2b_v1", 32'(ram_rvalid1), 32'd1);
      check("b2b_d1", ram_rdata1, 32'h10);
      tick();
      idle();
      check("b2b_v2", 32'(ram_rvalid1), 32'd1);
      check("b2b_d2", ram_rdata1, 32'h11);
      tick();
      check("b2b_v3", 32'(ram_rvalid1), 32'd1);
      check("b2b_d3", ram_rdata1, 32'h12);
      tick();
      check("b2b_vend", 32'(ram_rvalid1), 32'd0);
      check("b2b_hold", ram_rdata1, 32'h12);
      check("b2b_rv2", 32'(ram_rvalid2), 32'd0);

      // double write collision: port 2 wins
      ram_req1 = 1'b1; ram_w_en1 = 1'b1; ram_addr1 = 11'd7; ram_wdata1 = 32'hAAAA0000;
      ram_req2 = 1'b1; ram_w_en2 = 1'b1; ram_addr2 = 11'd7; ram_wdata2 = 32'h5555FFFF;
      tick();
      idle();
      check("wr_norv1", 32'(ram_rvalid1), 32'd0);
      check("wr_norv2", 32'(ram_rvalid2), 32'd0);
      do_read("ww7", 1, 11'd7, 32'h5555FFFF);

      // both ports read the same word
      ram_req1 = 1'b1; ram_w_en1 = 1'b0; ram_addr1 = 11'd7;
      ram_req2 = 1'b1; ram_w_en2 = 1'b0; ram_addr2 = 11'd7;
      tick();
      idle();
      tick();
      check("rr_v1", 32'(ram_rvalid1), 32'd1);
      check("rr_v2", 32'(ram_rvalid2), 32'd1);
      check("rr_d1", ram_rdata1, 32'h5555FFFF);
      check("rr_d2", ram_rdata2, 32'h5555FFFF);
      tick();

      // read vs write collision
      wr(2, 11'd9, 32'h1);
      ram_req1 = 1'b1; ram_w_en1 = 1'b0; ram_addr1 = 11'd9;
      ram_req2 = 1'b1; ram_w_en2 = 1'b1; ram_addr2 = 11'd9; ram_wdata2 = 32'h2;
      tick();
      idle();
      tick();
      check("rw_vld", 32'(ram_rvalid1), 32'd1);
      check("rw_dat", ram_rdata1, exp_fwd);
      check("rw_norv2", 32'(ram_rvalid2), 32'd0);
      tick();
      do_read("rw_after", 2, 11'd9, 32'h2);

      // out of range
      wr(1, 11'd1023, 32'h0000CAFE);
      check("oob_err0", 32'(err_addr), 32'd0);
      do_read("oob_rd", 2, 11'd2047, 32'd0);
      check("oob_err1", 32'(err_addr), 32'd1);
      wr(2, 11'd2047, 32'h12345678);
      tick(); tick();
      check("oob_sticky", 32'(err_addr), 32'd1);
      do_read("oob_alias", 1, 11'd1023, 32'h0000CAFE);

      // reset mid-read
      ram_req1 = 1'b1; ram_w_en1 = 1'b0; ram_addr1 = 11'd5;
      tick();
      idle();
      rst_n = 1'b0;
      #1;
      check("mr_rv", 32'(ram_rvalid1), 32'd0);
      check("mr_rd", ram_rdata1, 32'd0);
      check("mr_err", 32'(err_addr), 32'd0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("mr_norv", 32'(ram_rvalid1), 32'd0);
         tick();
      end
      check("mr_rd_after", ram_rdata1, 32'd0);
      do_read("persist5", 1, 11'd5, 32'hDEADBEEF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
